// File: rtl/sd_xfer_pkg.sv
// ============================================================================
// Module  : sd_xfer_pkg
// Brief   : Shared types and constants for the SD multi-sector sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sd_xfer_pkg;

    localparam int SEC_W = 32;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WFILL  = 4'd1,
        S_WISSUE = 4'd2,
        S_WBUSY  = 4'd3,
        S_RSPACE = 4'd4,
        S_RISSUE = 4'd5,
        S_RBUSY  = 4'd6,
        S_NEXT   = 4'd7,
        S_FIN    = 4'd8
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Show-ahead synchronous FIFO with occupancy count and flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DW-1:0]          din,
    input  logic                   pop,
    output logic [DW-1:0]          dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is still taken when the same cycle pops.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/sd_xfer_ctrl.sv
// ============================================================================
// Module  : sd_xfer_ctrl
// Brief   : Multi-sector read/write sequencer between host byte streams and
//           the SD sector engine. Optional watchdog: SD_XFER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sd_xfer_ctrl
    import sd_xfer_pkg::*;
#(
    parameter int DW         = 8,
    parameter int SEC_BYTES  = 512,
    parameter int FIFO_DEPTH = 1024,
    parameter int CNT_W      = 8,
    parameter int TO_CYC     = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_ok,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [SEC_W-1:0] cmd_sec,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DW-1:0]    wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [DW-1:0]    rd_data,
    output logic             sd_ren,
    output logic             sd_wen,
    output logic [SEC_W-1:0] sd_sec,
    input  logic             sd_wreq,
    output logic [DW-1:0]    sd_wdata,
    input  logic             sd_rvalid,
    input  logic [DW-1:0]    sd_rdata,
    input  logic             sd_rd_ok,
    input  logic             sd_wr_ok,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int SB_W = $clog2(SEC_BYTES);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int BW   = CNT_W + SB_W;

    state_t           state;
    logic             op;
    logic [CNT_W-1:0] cnt_lat;
    logic [CNT_W-1:0] remaining;
    logic [BW-1:0]    bytes_acc;

    logic [DW-1:0]    fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             wr_mode;
    logic             rd_mode;
    logic             accept;
    logic             wr_underrun;
    logic             rd_overrun;
    logic             to_hit;

    assign cmd_ready = (state == S_IDLE) && init_ok;
    assign accept    = cmd_valid && cmd_ready;

    assign wr_mode = (op == OP_WRITE) && (state inside {S_WFILL, S_WISSUE, S_WBUSY});
    assign rd_mode = (op == OP_READ) && (state != S_IDLE);

    // Host may keep filling while the SD engine drains the previous sector.
    assign wr_ready = wr_mode && !fifo_full && (bytes_acc < {cnt_lat, {SB_W{1'b0}}});
    assign rd_valid = rd_mode && !fifo_empty;

    assign fifo_push = rd_mode ? sd_rvalid : (wr_valid && wr_ready);
    assign fifo_pop  = rd_mode ? (rd_ready && !fifo_empty) : ((state == S_WBUSY) && sd_wreq);

    assign wr_underrun = (state == S_WBUSY) && sd_wreq && fifo_empty;
    assign rd_overrun  = rd_mode && sd_rvalid && fifo_full && !fifo_pop;

    assign sd_wdata = fifo_empty ? '0 : fifo_dout;
    assign rd_data  = fifo_empty ? '0 : fifo_dout;

`ifdef SD_XFER_TIMEOUT_EN
    logic [31:0] wd_cnt;

    // Completion on the limit cycle wins over the watchdog.
    assign to_hit = (((state == S_WBUSY) && !sd_wr_ok) || ((state == S_RBUSY) && !sd_rd_ok))
                    && (wd_cnt == 32'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || (state == S_WISSUE) || (state == S_RISSUE)) begin
            wd_cnt <= '0;
        end else if ((state == S_WBUSY) || (state == S_RBUSY)) begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end
`else
    logic unused_to;
    assign unused_to = ^TO_CYC;
    assign to_hit    = 1'b0;
`endif

    sync_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (to_hit),
        .push  (fifo_push),
        .din   (rd_mode ? sd_rdata : wr_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op        <= OP_READ;
            cnt_lat   <= '0;
            remaining <= '0;
            bytes_acc <= '0;
            sd_sec    <= '0;
            sd_ren    <= 1'b0;
            sd_wen    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            sd_ren <= 1'b0;
            sd_wen <= 1'b0;
            done   <= 1'b0;
            err    <= wr_underrun || rd_overrun;
            if (wr_valid && wr_ready) begin
                bytes_acc <= bytes_acc + BW'(1);
            end

            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (accept) begin
                        op        <= cmd_op;
                        sd_sec    <= cmd_sec;
                        cnt_lat   <= cmd_cnt;
                        remaining <= cmd_cnt;
                        bytes_acc <= '0;
                        busy      <= 1'b1;
                        if (cmd_cnt == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= (cmd_op == OP_WRITE) ? S_WFILL : S_RSPACE;
                        end
                    end
                end
                S_WFILL: begin
                    if (fifo_count >= CW'(SEC_BYTES)) begin
                        state  <= S_WISSUE;
                        sd_wen <= 1'b1;
                    end
                end
                S_WISSUE: state <= S_WBUSY;
                S_WBUSY: begin
                    if (sd_wr_ok) begin
                        state <= S_NEXT;
                    end else if (to_hit) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end
                end
                S_RSPACE: begin
                    if ((CW'(FIFO_DEPTH) - fifo_count) >= CW'(SEC_BYTES)) begin
                        state  <= S_RISSUE;
                        sd_ren <= 1'b1;
                    end
                end
                S_RISSUE: state <= S_RBUSY;
                S_RBUSY: begin
                    if (sd_rd_ok) begin
                        state <= S_NEXT;
                    end else if (to_hit) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end
                end
                S_NEXT: begin
                    sd_sec    <= sd_sec + 32'd1;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state <= S_FIN;
                    end else begin
                        state <= (op == OP_WRITE) ? S_WFILL : S_RSPACE;
                    end
                end
                S_FIN: begin
                    if ((op == OP_WRITE) || fifo_empty) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
